// File: rtl/ad9833_pkg.sv
// Shared constants and types for the AD9833 serial-write receiver.
// Address codes, bit positions and the receiver's visible state record live here.
package ad9833_pkg;

    localparam int WORD_W  = 16;
    localparam int FREQ_W  = 28;
    localparam int PHASE_W = 12;
    localparam int DATA_W  = 14;

    localparam logic [1:0] ADDR_CTRL = 2'b00;
    localparam logic [1:0] ADDR_F0   = 2'b01;
    localparam logic [1:0] ADDR_F1   = 2'b10;
    localparam logic [1:0] ADDR_PH   = 2'b11;

    localparam int B28_BIT   = 13;
    localparam int HLB_BIT   = 12;
    localparam int PHSEL_BIT = 13;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

    // Complete receiver state in one record so checkers can bind to a single signal.
    typedef struct packed {
        rx_state_t           state;
        logic [3:0]          bit_cnt;
        logic [WORD_W-1:0]   shift;
        logic                armed;
    } rx_regs_t;

    function automatic logic [1:0] word_addr(input logic [WORD_W-1:0] w);
        return w[WORD_W-1 -: 2];
    endfunction

endpackage

// File: rtl/ad9833_pin_sync.sv
// Synchronizes fsync/sclk/sdata into i_clk and produces registered
// sclk-fall and fsync-rise pulses with level outputs aligned to them.
module ad9833_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_fsync,
    input  logic i_sclk,
    input  logic i_sdata,
    output logic fsync_lvl,
    output logic sdata_lvl,
    output logic sclk_fall,
    output logic fsync_rise
);

    // Bit order within each stage: {fsync, sclk, sdata}.
    logic [2:0] sync_q [SYNC_STAGES];
    logic [2:0] tap;
    logic       sclk_d;
    logic       fsync_d;

    assign tap = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 3'b000;
            end
        end else begin
            sync_q[0] <= {i_fsync, i_sclk, i_sdata};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_d     <= 1'b0;
            fsync_d    <= 1'b0;
            sclk_fall  <= 1'b0;
            fsync_rise <= 1'b0;
            fsync_lvl  <= 1'b0;
            sdata_lvl  <= 1'b0;
        end else begin
            sclk_d     <= tap[1];
            fsync_d    <= tap[2];
            sclk_fall  <= sclk_d & ~tap[1];
            fsync_rise <= ~fsync_d & tap[2];
            fsync_lvl  <= tap[2];
            sdata_lvl  <= tap[0];
        end
    end

endmodule

// File: rtl/ad9833_spi_rx.sv
// AD9833 serial-write receiver: assembles 16-bit words from the oversampled
// bus and decodes them into CONTROL / FREQ0/1 / PHASE0/1 register images.
module ad9833_spi_rx
    import ad9833_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_fsync,
    input  logic               i_sclk,
    input  logic               i_sdata,
    output logic [WORD_W-1:0]  o_word,
    output logic               o_word_dv,
    output logic [WORD_W-1:0]  o_control,
    output logic [FREQ_W-1:0]  o_freq0,
    output logic [FREQ_W-1:0]  o_freq1,
    output logic [PHASE_W-1:0] o_phase0,
    output logic [PHASE_W-1:0] o_phase1,
    output logic               o_reg_update,
    output logic               o_frame_err
);

    logic fsync_lvl;
    logic sdata_lvl;
    logic sclk_fall;
    logic fsync_rise;

    ad9833_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_fsync    (i_fsync),
        .i_sclk     (i_sclk),
        .i_sdata    (i_sdata),
        .fsync_lvl  (fsync_lvl),
        .sdata_lvl  (sdata_lvl),
        .sclk_fall  (sclk_fall),
        .fsync_rise (fsync_rise)
    );

    rx_regs_t          rx_q;
    rx_regs_t          rx_n;
    logic [WORD_W-1:0] word_n;
    logic              word_load;
    logic              frame_err_n;

    // armed: fsync has been seen high since reset, so a frame cut by reset
    // is never resumed; reception restarts only on a fresh fsync fall.
    always_comb begin
        rx_n        = rx_q;
        word_load   = 1'b0;
        frame_err_n = 1'b0;
        word_n      = {rx_q.shift[WORD_W-2:0], sdata_lvl};
        if (fsync_lvl) begin
            rx_n.armed = 1'b1;
        end
        case (rx_q.state)
            ST_IDLE: begin
                if (rx_q.armed && !fsync_lvl) begin
                    rx_n.state   = ST_SHIFT;
                    rx_n.bit_cnt = 4'd0;
                end
            end
            ST_SHIFT: begin
                if (fsync_rise) begin
                    frame_err_n  = (rx_q.bit_cnt != 4'd0);
                    rx_n.bit_cnt = 4'd0;
                    rx_n.state   = ST_IDLE;
                end else if (sclk_fall && !fsync_lvl) begin
                    rx_n.shift   = word_n;
                    rx_n.bit_cnt = rx_q.bit_cnt + 4'd1;
                    word_load    = (rx_q.bit_cnt == 4'd15);
                end
            end
            default: begin
                rx_n.state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_q        <= '0;
            o_word      <= '0;
            o_word_dv   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            rx_q        <= rx_n;
            o_word_dv   <= word_load;
            o_frame_err <= frame_err_n;
            if (word_load) begin
                o_word <= word_n;
            end
        end
    end

    // Decode runs one cycle behind o_word_dv on the registered word.
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] shadow;
    logic              pending;
    logic              pend_f1;

    assign data = o_word[DATA_W-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_control    <= '0;
            o_freq0      <= '0;
            o_freq1      <= '0;
            o_phase0     <= '0;
            o_phase1     <= '0;
            o_reg_update <= 1'b0;
            shadow       <= '0;
            pending      <= 1'b0;
            pend_f1      <= 1'b0;
        end else begin
            o_reg_update <= 1'b0;
            if (o_word_dv) begin
                case (word_addr(o_word))
                    ADDR_CTRL: begin
                        o_control    <= o_word;
                        pending      <= 1'b0;
                        o_reg_update <= 1'b1;
                    end
                    ADDR_F0, ADDR_F1: begin
                        if (o_control[B28_BIT]) begin
                            if (!pending) begin
                                shadow  <= data;
                                pend_f1 <= (word_addr(o_word) == ADDR_F1);
                                pending <= 1'b1;
                            end else begin
                                // Target comes from the first word; this word's address is ignored.
                                if (pend_f1) begin
                                    o_freq1 <= {data, shadow};
                                end else begin
                                    o_freq0 <= {data, shadow};
                                end
                                pending      <= 1'b0;
                                o_reg_update <= 1'b1;
                            end
                        end else begin
                            if (word_addr(o_word) == ADDR_F1) begin
                                if (o_control[HLB_BIT]) o_freq1[FREQ_W-1:DATA_W] <= data;
                                else                    o_freq1[DATA_W-1:0]      <= data;
                            end else begin
                                if (o_control[HLB_BIT]) o_freq0[FREQ_W-1:DATA_W] <= data;
                                else                    o_freq0[DATA_W-1:0]      <= data;
                            end
                            o_reg_update <= 1'b1;
                        end
                    end
                    default: begin
                        if (o_word[PHSEL_BIT]) begin
                            o_phase1 <= o_word[PHASE_W-1:0];
                        end else begin
                            o_phase0 <= o_word[PHASE_W-1:0];
                        end
                        o_reg_update <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ad9833_spi_rx.sv
// Directed bench for ad9833_spi_rx: drives AD9833 write frames with sclk at
// 1/10 of i_clk and checks words, register images and pulse counts.
module tb_ad9833_spi_rx;

    logic        i_clk;
    logic        i_rst;
    logic        i_fsync;
    logic        i_sclk;
    logic        i_sdata;
    logic [15:0] o_word;
    logic        o_word_dv;
    logic [15:0] o_control;
    logic [27:0] o_freq0;
    logic [27:0] o_freq1;
    logic [11:0] o_phase0;
    logic [11:0] o_phase1;
    logic        o_reg_update;
    logic        o_frame_err;

    ad9833_spi_rx #(.SYNC_STAGES(2)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_fsync      (i_fsync),
        .i_sclk       (i_sclk),
        .i_sdata      (i_sdata),
        .o_word       (o_word),
        .o_word_dv    (o_word_dv),
        .o_control    (o_control),
        .o_freq0      (o_freq0),
        .o_freq1      (o_freq1),
        .o_phase0     (o_phase0),
        .o_phase1     (o_phase1),
        .o_reg_update (o_reg_update),
        .o_frame_err  (o_frame_err)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #10 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: expected words in order of transmission
    logic [15:0] exp_q[$];
    int cyc = 0;
    int dv_cnt = 0;
    int upd_cnt = 0;
    int err_cnt = 0;
    int last_dv_cyc = 0;
    int last_upd_cyc = 0;

    always @(negedge i_clk) begin
        cyc++;
        if (!i_rst) begin
            if (o_word_dv) begin
                dv_cnt++;
                last_dv_cyc = cyc;
                if (exp_q.size() != 0) check("word", 32'(o_word), 32'(exp_q.pop_front()));
                else                   check("dv_unexpected", 32'(o_word_dv), 32'd0);
            end
            if (o_reg_update) begin
                upd_cnt++;
                last_upd_cyc = cyc;
            end
            if (o_frame_err) err_cnt++;
        end
    end

    // driver tasks
    task automatic wait_clks(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic send_bits(input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            i_sdata = w[15-i];
            i_sclk  = 1'b1;
            wait_clks(5);
            i_sclk  = 1'b0;
            wait_clks(5);
        end
    endtask

    task automatic frame_start();
        i_sclk  = 1'b1;
        i_fsync = 1'b0;
        wait_clks(5);
    endtask

    task automatic frame_end();
        wait_clks(5);
        i_fsync = 1'b1;
        wait_clks(12);
    endtask

    task automatic send_word(input logic [15:0] w);
        exp_q.push_back(w);
        frame_start();
        send_bits(w, 16);
        frame_end();
    endtask

    int dv0, upd0, err0;

    initial begin
        i_rst   = 1'b1;
        i_fsync = 1'b1;
        i_sclk  = 1'b1;
        i_sdata = 1'b0;
        wait_clks(3);
        check("rst_word",    32'(o_word),    32'd0);
        check("rst_dv",      32'(o_word_dv), 32'd0);
        check("rst_control", 32'(o_control), 32'd0);
        check("rst_freq0",   32'(o_freq0),   32'd0);
        check("rst_phase1",  32'(o_phase1),  32'd0);
        i_rst = 1'b0;
        wait_clks(10);

        // CONTROL write
        dv0 = dv_cnt; upd0 = upd_cnt;
        send_word(16'h2000);
        check("ctrl_dv_cnt",  dv_cnt - dv0, 1);
        check("ctrl_value",   32'(o_control), 32'h2000);
        check("ctrl_upd_cnt", upd_cnt - upd0, 1);
        check("ctrl_upd_lat", last_upd_cyc - last_dv_cyc, 1);

        // B28 two-word write to FREQ0
        upd0 = upd_cnt;
        send_word(16'h40F0);
        check("b28_first_no_upd", upd_cnt - upd0, 0);
        check("b28_first_freq0",  32'(o_freq0), 32'd0);
        send_word(16'h4000);
        check("b28_second_upd", upd_cnt - upd0, 1);
        check("b28_freq0",      32'(o_freq0), 32'h00000F0);
        check("b28_freq1",      32'(o_freq1), 32'd0);

        // HLB half writes
        send_word(16'h1000);
        send_word(16'h4ABC);
        check("hlb_freq0_msb", 32'(o_freq0), 32'h2AF00F0);
        send_word(16'h0000);
        send_word(16'h8123);
        check("hlb_freq1_lsb", 32'(o_freq1), 32'h0000123);
        check("hlb_freq0_keep", 32'(o_freq0), 32'h2AF00F0);

        // two phase words in one frame
        dv0 = dv_cnt;
        exp_q.push_back(16'hC123);
        exp_q.push_back(16'hE456);
        frame_start();
        send_bits(16'hC123, 16);
        send_bits(16'hE456, 16);
        frame_end();
        check("multi_dv_cnt", dv_cnt - dv0, 2);
        check("phase0",       32'(o_phase0), 32'h123);
        check("phase1",       32'(o_phase1), 32'h456);

        // partial frame of 9 bits
        dv0 = dv_cnt; err0 = err_cnt; upd0 = upd_cnt;
        frame_start();
        send_bits(16'hFFFF, 9);
        frame_end();
        check("partial_err_cnt", err_cnt - err0, 1);
        check("partial_no_dv",   dv_cnt - dv0, 0);
        check("partial_no_upd",  upd_cnt - upd0, 0);
        check("partial_control", 32'(o_control), 32'h0000);
        check("partial_phase0",  32'(o_phase0), 32'h123);
        send_word(16'h0040);
        check("after_partial_ctrl", 32'(o_control), 32'h0040);
        check("after_partial_err",  err_cnt - err0, 1);

        // reset in the middle of a frame with a B28 half pending
        send_word(16'h2000);
        send_word(16'h4111);
        err0 = err_cnt;
        frame_start();
        send_bits(16'hAAAA, 7);
        i_rst = 1'b1;
        #1;
        check("midrst_word",    32'(o_word),    32'd0);
        check("midrst_control", 32'(o_control), 32'd0);
        check("midrst_freq0",   32'(o_freq0),   32'd0);
        check("midrst_freq1",   32'(o_freq1),   32'd0);
        check("midrst_phase0",  32'(o_phase0),  32'd0);
        wait_clks(3);
        i_rst = 1'b0;
        wait_clks(6);
        i_sclk  = 1'b1;
        i_fsync = 1'b1;
        wait_clks(12);
        check("midrst_no_err", err_cnt - err0, 0);
        send_word(16'h2000);
        check("post_rst_ctrl", 32'(o_control), 32'h2000);
        send_word(16'h4007);
        send_word(16'h4000);
        check("post_rst_freq0", 32'(o_freq0), 32'h0000007);

        check("exp_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
